// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: the sequencer state set, the default
// address stride, and the "first non-empty phase" selection rule.
package cpu_run_ctrl_pkg;

  localparam int unsigned ADDR_STEP_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_CAP,
    ST_DUMP_OUT
  } state_e;

  // Phases always run in LOAD -> RUN -> DUMP order, and empty phases are skipped.
  function automatic state_e first_phase(input logic has_prog,
                                         input logic has_run,
                                         input logic has_dump);
    state_e nxt;
    if (has_prog)      nxt = ST_LOAD;
    else if (has_run)  nxt = ST_RUN;
    else if (has_dump) nxt = ST_DUMP_RD;
    else               nxt = ST_IDLE;
    return nxt;
  endfunction

endpackage

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low reset; holds the latched
// run configuration between accepted start pulses.
module reg_arstn_en #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is always written with <=, so every flop samples
  // the values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  q <= RST_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: streams a program into imem while the core is held
// in reset, runs it for a cycle budget, then streams a dmem window back out.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  prog_len,
  input  logic [CNT_W-1:0]  run_len,
  input  logic [31:0]       dump_base,
  input  logic [CNT_W-1:0]  dump_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic [31:0]       imem_addr_ext,
  output logic              imem_wen_ext,
  output logic [DATA_W-1:0] imem_wdata_ext,
  output logic [31:0]       dmem_addr_ext,
  output logic              dmem_ren_ext,
  input  logic [DATA_W-1:0] dmem_rdata_ext,
  output logic              cpu_arst_n,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CFG_W = 3 * CNT_W + 32;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                cpu_arst_n_q, cpu_arst_n_d;
  logic                cpu_enable_q, cpu_enable_d;

  logic [CFG_W-1:0]    cfg_q;
  logic [CNT_W-1:0]    prog_len_q, run_len_q, dump_len_q;
  logic [31:0]         dump_base_q;
  logic                cfg_en;
  logic [31:0]         step_addr;

  assign cfg_en = start && (state_q == ST_IDLE);

  reg_arstn_en #(.WIDTH(CFG_W)) u_cfg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (cfg_en),
    .d      ({prog_len, run_len, dump_len, dump_base}),
    .q      (cfg_q)
  );

  assign {prog_len_q, run_len_q, dump_len_q, dump_base_q} = cfg_q;

  // Byte offset of the current word; wraps modulo 2^32 by construction.
  assign step_addr = 32'(idx_q) * 32'(ADDR_STEP);

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
    done_d      = done_q;
    dump_data_d = dump_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = '0;
          run_cnt_d = run_len;
          state_d   = first_phase(prog_len != '0, run_len != '0, dump_len != '0);
          done_d    = (state_d == ST_IDLE);
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (idx_q == prog_len_q - ONE) begin
            idx_d   = '0;
            state_d = first_phase(1'b0, run_len_q != '0, dump_len_q != '0);
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q - ONE;
        if (run_cnt_q == ONE) state_d = first_phase(1'b0, 1'b0, dump_len_q != '0);
      end
      ST_DUMP_RD:  state_d = ST_DUMP_CAP;
      ST_DUMP_CAP: begin
        dump_data_d = dmem_rdata_ext;
        state_d     = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        if (dump_ready) begin
          if (idx_q == dump_len_q - ONE) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && state_d == ST_IDLE) done_d = 1'b1;

    // Core reset is released from the first RUN cycle until the return to IDLE.
    cpu_arst_n_d = !(state_d inside {ST_IDLE, ST_LOAD});
    cpu_enable_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      run_cnt_q    <= '0;
      done_q       <= 1'b0;
      dump_data_q  <= '0;
      cpu_arst_n_q <= 1'b0;
      cpu_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_cnt_q    <= run_cnt_d;
      done_q       <= done_d;
      dump_data_q  <= dump_data_d;
      cpu_arst_n_q <= cpu_arst_n_d;
      cpu_enable_q <= cpu_enable_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign cpu_arst_n     = cpu_arst_n_q;
  assign cpu_enable     = cpu_enable_q;
  assign load_ready     = (state_q == ST_LOAD);
  assign imem_wen_ext   = load_ready && load_valid;
  assign imem_addr_ext  = load_ready ? step_addr : '0;
  assign imem_wdata_ext = imem_wen_ext ? load_data : '0;
  assign dmem_ren_ext   = (state_q == ST_DUMP_RD);
  assign dmem_addr_ext  = dmem_ren_ext ? dump_base_q + step_addr : '0;
  assign dump_valid     = (state_q == ST_DUMP_OUT);
  assign dump_data      = dump_data_q;

endmodule
